// File: rtl/alu_exec_broadcast.sv
// ALU execute stage with a result FIFO that drives the shared result broadcast bus.
// Define ALU_EXEC_BYPASS_EN to broadcast straight from EX when the FIFO is empty.

package common;
  typedef logic [3:0] alu_cmd_t;
  localparam alu_cmd_t ALU_ADD  = 4'd0;
  localparam alu_cmd_t ALU_SUB  = 4'd1;
  localparam alu_cmd_t ALU_AND  = 4'd2;
  localparam alu_cmd_t ALU_OR   = 4'd3;
  localparam alu_cmd_t ALU_XOR  = 4'd4;
  localparam alu_cmd_t ALU_SLL  = 4'd5;
  localparam alu_cmd_t ALU_SRL  = 4'd6;
  localparam alu_cmd_t ALU_SRA  = 4'd7;
  localparam alu_cmd_t ALU_SLT  = 4'd8;
  localparam alu_cmd_t ALU_SLTU = 4'd9;
endpackage

module alu_exec_broadcast #(
  parameter int RESULT_FIFO_DEPTH = 4,
  parameter int PHYS_TAG_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alu_cmd_valid,
  input  common::alu_cmd_t      issue_alu_cmd,
  input  logic [31:0]           issue_op1,
  input  logic [31:0]           issue_op2,
  input  logic [PHYS_TAG_W-1:0] phys_rd,
  output logic                  ex_ready,
  input  logic                  bc_grant,
  output logic                  phys_result_valid,
  output logic [PHYS_TAG_W-1:0] phys_result_tag,
  output logic [31:0]           phys_result_data,
  output logic                  issue_dropped
);
  import common::*;

  localparam int PTR_W = $clog2(RESULT_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(RESULT_FIFO_DEPTH);

  logic                  ex_valid_q, ex_valid_d;
  alu_cmd_t              ex_cmd_q, ex_cmd_d;
  logic [31:0]           ex_op1_q, ex_op1_d;
  logic [31:0]           ex_op2_q, ex_op2_d;
  logic [PHYS_TAG_W-1:0] ex_rd_q, ex_rd_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  dropped_q, dropped_d;

  logic [PHYS_TAG_W-1:0] tag_mem  [RESULT_FIFO_DEPTH];
  logic [31:0]           data_mem [RESULT_FIFO_DEPTH];

  logic [31:0]    ex_result;
  logic [CNT_W:0] occupancy;
  logic           fifo_nonempty, bypass_hit, accept, push, pop;

  // Occupancy counts the EX op too, so an accepted op always has a FIFO slot waiting.
  assign occupancy     = {1'b0, count_q} + {{CNT_W{1'b0}}, ex_valid_q};
  assign ex_ready      = occupancy < DEPTH_L;
  assign fifo_nonempty = (count_q != '0);
`ifdef ALU_EXEC_BYPASS_EN
  assign bypass_hit    = !fifo_nonempty && ex_valid_q;
`else
  assign bypass_hit    = 1'b0;
`endif
  assign accept        = alu_cmd_valid && ex_ready && !flush;
  assign pop           = fifo_nonempty && bc_grant && !flush;
  assign push          = ex_valid_q && !flush && !(bypass_hit && bc_grant);
  assign issue_dropped = dropped_q;

  always_comb begin
    ex_result = '0;
    case (ex_cmd_q)
      ALU_ADD:  ex_result = ex_op1_q + ex_op2_q;
      ALU_SUB:  ex_result = ex_op1_q - ex_op2_q;
      ALU_AND:  ex_result = ex_op1_q & ex_op2_q;
      ALU_OR:   ex_result = ex_op1_q | ex_op2_q;
      ALU_XOR:  ex_result = ex_op1_q ^ ex_op2_q;
      ALU_SLL:  ex_result = ex_op1_q << ex_op2_q[4:0];
      ALU_SRL:  ex_result = ex_op1_q >> ex_op2_q[4:0];
      ALU_SRA:  ex_result = $unsigned($signed(ex_op1_q) >>> ex_op2_q[4:0]);
      ALU_SLT:  ex_result = {31'b0, $signed(ex_op1_q) < $signed(ex_op2_q)};
      ALU_SLTU: ex_result = {31'b0, ex_op1_q < ex_op2_q};
      default:  ex_result = '0;
    endcase
  end

  always_comb begin
    phys_result_valid = 1'b0;
    phys_result_tag   = '0;
    phys_result_data  = '0;
    if (fifo_nonempty) begin
      phys_result_valid = 1'b1;
      phys_result_tag   = tag_mem[rd_ptr_q];
      phys_result_data  = data_mem[rd_ptr_q];
    end else if (bypass_hit) begin
      phys_result_valid = 1'b1;
      phys_result_tag   = ex_rd_q;
      phys_result_data  = ex_result;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_cmd_d   = ex_cmd_q;
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    ex_rd_d    = ex_rd_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    dropped_d  = dropped_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      ex_valid_d = accept;
      if (accept) begin
        ex_cmd_d = issue_alu_cmd;
        ex_op1_d = issue_op1;
        ex_op2_d = issue_op2;
        ex_rd_d  = phys_rd;
      end
      if (alu_cmd_valid && !ex_ready) dropped_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_cmd_q   <= '0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_rd_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      dropped_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_cmd_q   <= ex_cmd_d;
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
      ex_rd_q    <= ex_rd_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      dropped_q  <= dropped_d;
    end
  end

  // Result storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      tag_mem[wr_ptr_q]  <= ex_rd_q;
      data_mem[wr_ptr_q] <= ex_result;
    end
  end

endmodule
